// File: rtl/debouncer_multi.sv
// ----------------------------------------------------------------------------
// debouncer_multi
//
// Multi-channel switch debouncer. Each of the N_CH raw switch inputs passes
// through a SYNC_STAGES-deep synchroniser. It then goes through a four-state
// stability FSM with a saturating run counter. The FSM drives a clean level,
// one-cycle rise/fall event pulses and a toggle latch. All outputs come
// straight from flops, so there is no combinational path from sw_i to any
// output.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   sw_i          [N_CH]  raw asynchronous switch inputs
//   cfg_cycles_i  [CNT_W] stable-sample threshold (0 behaves as 1), read
//                         every cycle
//   db_o          [N_CH]  debounced level per channel
//   rise_o        [N_CH]  one-cycle pulse on the cycle db_o goes 0->1
//   fall_o        [N_CH]  one-cycle pulse on the cycle db_o goes 1->0
//   toggle_o      [N_CH]  flips on every rise_o of its channel
//   busy_o                high while any channel is checking a new level
// ----------------------------------------------------------------------------
module debouncer_multi #(
    parameter int   N_CH        = 4,
    parameter int   CNT_W       = 16,
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT_LEVEL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  sw_i,
    input  logic [CNT_W-1:0] cfg_cycles_i,
    output logic [N_CH-1:0]  db_o,
    output logic [N_CH-1:0]  rise_o,
    output logic [N_CH-1:0]  fall_o,
    output logic [N_CH-1:0]  toggle_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHECK_HI  = 2'd1,
        STABLE_HI = 2'd2,
        CHECK_LO  = 2'd3
    } state_t;

    localparam state_t RESET_STATE = INIT_LEVEL ? STABLE_HI : STABLE_LO;

    // The counter holds the number of matching samples seen *before* the
    // current one. A level is therefore accepted once cnt >= thr-1, which
    // counts the sample being evaluated now. A zero threshold is treated as
    // one, so thr-1 is 0 in both cases and never underflows.
    logic [CNT_W-1:0] w_thrMinus1;
    assign w_thrMinus1 = (cfg_cycles_i == '0) ? '0 : cfg_cycles_i - CNT_W'(1);

    logic [N_CH-1:0] w_checkNext;

    genvar ch;
    generate
        for (ch = 0; ch < N_CH; ch++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic                   w_swS;
            state_t                 r_state;
            state_t                 w_stateNext;
            logic [CNT_W-1:0]       r_cnt;
            logic [CNT_W-1:0]       w_cntNext;
            logic [CNT_W-1:0]       w_cntInc;
            logic                   w_thrReached;
            logic                   r_db;
            logic                   w_dbNext;
            logic                   r_rise;
            logic                   w_riseNext;
            logic                   r_fall;
            logic                   w_fallNext;
            logic                   r_tog;
            logic                   w_togNext;

            // Synchroniser shift chain; the MSB is the settled sample.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync <= {SYNC_STAGES{INIT_LEVEL}};
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], sw_i[ch]};
                end
            end

            assign w_swS        = r_sync[SYNC_STAGES-1];
            // Saturate rather than wrap so that a huge threshold cannot be
            // met by accident after an overflow.
            assign w_cntInc     = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
            assign w_thrReached = (r_cnt >= w_thrMinus1);

            // Next-state, counter and registered-output logic of the
            // channel's stability FSM.
            always_comb begin
                w_stateNext = r_state;
                w_cntNext   = r_cnt;
                w_dbNext    = r_db;
                w_riseNext  = 1'b0;
                w_fallNext  = 1'b0;
                w_togNext   = r_tog;

                unique case (r_state)
                    STABLE_LO: begin
                        if (w_swS) begin
                            if (w_thrMinus1 == '0) begin
                                w_stateNext = STABLE_HI;
                                w_dbNext    = 1'b1;
                                w_riseNext  = 1'b1;
                                w_togNext   = ~r_tog;
                                w_cntNext   = '0;
                            end else begin
                                w_stateNext = CHECK_HI;
                                w_cntNext   = CNT_W'(1);
                            end
                        end
                    end
                    CHECK_HI: begin
                        if (!w_swS) begin
                            w_stateNext = STABLE_LO;
                            w_cntNext   = '0;
                        end else if (w_thrReached) begin
                            w_stateNext = STABLE_HI;
                            w_dbNext    = 1'b1;
                            w_riseNext  = 1'b1;
                            w_togNext   = ~r_tog;
                            w_cntNext   = '0;
                        end else begin
                            w_cntNext   = w_cntInc;
                        end
                    end
                    STABLE_HI: begin
                        if (!w_swS) begin
                            if (w_thrMinus1 == '0) begin
                                w_stateNext = STABLE_LO;
                                w_dbNext    = 1'b0;
                                w_fallNext  = 1'b1;
                                w_cntNext   = '0;
                            end else begin
                                w_stateNext = CHECK_LO;
                                w_cntNext   = CNT_W'(1);
                            end
                        end
                    end
                    CHECK_LO: begin
                        if (w_swS) begin
                            w_stateNext = STABLE_HI;
                            w_cntNext   = '0;
                        end else if (w_thrReached) begin
                            w_stateNext = STABLE_LO;
                            w_dbNext    = 1'b0;
                            w_fallNext  = 1'b1;
                            w_cntNext   = '0;
                        end else begin
                            w_cntNext   = w_cntInc;
                        end
                    end
                    default: begin
                        w_stateNext = RESET_STATE;
                        w_cntNext   = '0;
                    end
                endcase
            end

            // State, counter and output registers of the channel.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state <= RESET_STATE;
                    r_cnt   <= '0;
                    r_db    <= INIT_LEVEL;
                    r_rise  <= 1'b0;
                    r_fall  <= 1'b0;
                    r_tog   <= 1'b0;
                end else begin
                    r_state <= w_stateNext;
                    r_cnt   <= w_cntNext;
                    r_db    <= w_dbNext;
                    r_rise  <= w_riseNext;
                    r_fall  <= w_fallNext;
                    r_tog   <= w_togNext;
                end
            end

            assign w_checkNext[ch] = (w_stateNext == CHECK_HI) ||
                                     (w_stateNext == CHECK_LO);
            assign db_o[ch]        = r_db;
            assign rise_o[ch]      = r_rise;
            assign fall_o[ch]      = r_fall;
            assign toggle_o[ch]    = r_tog;
        end
    endgenerate

    // busy is loaded from the next-state decode, so it is a flop that stays
    // aligned with the state registers rather than lagging them by a cycle.
    logic r_busy;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= |w_checkNext;
        end
    end

    assign busy_o = r_busy;

endmodule

// File: tb/tb_debouncer_multi.sv
// ----------------------------------------------------------------------------
// tb_debouncer_multi
//
// Directed bench for debouncer_multi with N_CH=4, CNT_W=16, SYNC_STAGES=2 and
// INIT_LEVEL=0. Inputs change on the falling edge and outputs are sampled
// there too, half a period away from the active edge.
//
// Each table entry holds a set of inputs, the number of clocks to hold them
// and the outputs expected after that many clocks. Hand-written sequences
// cover bouncing, channel independence, threshold changes and reset in the
// middle of a count.
// ----------------------------------------------------------------------------
module tb_debouncer_multi;

    logic        clk;
    logic        rst;
    logic [3:0]  sw;
    logic [15:0] cfg;
    logic [3:0]  db;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic [3:0]  tog;
    logic        busy;

    int nCompared;
    int nFailed;

    debouncer_multi #(
        .N_CH        (4),
        .CNT_W       (16),
        .SYNC_STAGES (2),
        .INIT_LEVEL  (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_i         (sw),
        .cfg_cycles_i (cfg),
        .db_o         (db),
        .rise_o       (rise),
        .fall_o       (fall),
        .toggle_o     (tog),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  sw;
        logic [15:0] cfg;
        int          cycles;
        logic [3:0]  db;
        logic [3:0]  rise;
        logic [3:0]  fall;
        logic [3:0]  tog;
        logic        busy;
    } vec_t;

    vec_t  vecs [32];
    string vecNames [32];
    int    nVec;

    // Bounce-window model state for channel 1.
    logic  hist [0:4095];
    int    pIdx;
    logic  mDb;
    int    mRise;
    int    mFall;
    int    dRise;
    int    dFall;
    int    dbBad;

    task automatic addVec(input string name, input logic r, input logic [3:0] s,
                          input logic [15:0] c, input int n,
                          input logic [3:0] eDb, input logic [3:0] eRise,
                          input logic [3:0] eFall, input logic [3:0] eTog,
                          input logic eBusy);
        vecs[nVec].rst    = r;
        vecs[nVec].sw     = s;
        vecs[nVec].cfg    = c;
        vecs[nVec].cycles = n;
        vecs[nVec].db     = eDb;
        vecs[nVec].rise   = eRise;
        vecs[nVec].fall   = eFall;
        vecs[nVec].tog    = eTog;
        vecs[nVec].busy   = eBusy;
        vecNames[nVec]    = name;
        nVec++;
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] s,
                                 input logic [15:0] c, input int n);
        rst = r;
        sw  = s;
        cfg = c;
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] eDb,
                               input logic [3:0] eRise, input logic [3:0] eFall,
                               input logic [3:0] eTog, input logic eBusy);
        nCompared++;
        if ({db, rise, fall, tog, busy} !== {eDb, eRise, eFall, eTog, eBusy}) begin
            nFailed++;
            $display("[TB] FAIL %s: got db=%b rise=%b fall=%b tog=%b busy=%b, want db=%b rise=%b fall=%b tog=%b busy=%b",
                     name, db, rise, fall, tog, busy, eDb, eRise, eFall, eTog, eBusy);
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nFailed++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        sw  = 4'b0000;
        cfg = 16'd10;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Drives one cycle of channel 1 and advances the window model. A level
    // is accepted once the last ten synchronised samples (input delayed by
    // two clocks) all differ from the current model level.
    task automatic stepCh1(input logic v);
        logic allNew;
        int   idx;
        logic smp;
        sw[1] = v;
        @(negedge clk);
        pIdx++;
        hist[pIdx] = v;
        allNew = 1'b1;
        for (int k = 0; k < 10; k++) begin
            idx = pIdx - 2 - k;
            smp = (idx >= 1) ? hist[idx] : 1'b0;
            if (smp == mDb) allNew = 1'b0;
        end
        if (allNew) begin
            mDb = ~mDb;
            if (mDb) mRise++;
            else     mFall++;
        end
        if (db[1] !== mDb) dbBad++;
        dRise += int'(rise[1]);
        dFall += int'(fall[1]);
    endtask

    initial begin
        int   obsRise;
        int   obsFall;
        int   obsHigh;
        int   riseP2;
        int   riseP3;
        int   busyBad;
        int   db0Bad;
        int   w;

        nCompared = 0;
        nFailed   = 0;
        nVec      = 0;
        rst = 1'b1;
        sw  = 4'b0000;
        cfg = 16'd10;

        // name, rst, sw, cfg, cycles, db, rise, fall, tog, busy
        addVec("reset_hold",          1, 4'b0000, 16'd10,     2,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        addVec("reset_idle",          0, 4'b0000, 16'd10,     12, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        addVec("press_sync",          0, 4'b0001, 16'd10,     2,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        addVec("press_check",         0, 4'b0001, 16'd10,     1,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
        addVec("press_wait",          0, 4'b0001, 16'd10,     8,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
        addVec("press_commit",        0, 4'b0001, 16'd10,     1,  4'b0001, 4'b0001, 4'b0000, 4'b0001, 0);
        addVec("press_pulse_end",     0, 4'b0001, 16'd10,     1,  4'b0001, 4'b0000, 4'b0000, 4'b0001, 0);
        addVec("press_hold",          0, 4'b0001, 16'd10,     15, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0);
        addVec("release_sync",        0, 4'b0000, 16'd10,     2,  4'b0001, 4'b0000, 4'b0000, 4'b0001, 0);
        addVec("release_check",       0, 4'b0000, 16'd10,     1,  4'b0001, 4'b0000, 4'b0000, 4'b0001, 1);
        addVec("release_wait",        0, 4'b0000, 16'd10,     8,  4'b0001, 4'b0000, 4'b0000, 4'b0001, 1);
        addVec("release_commit",      0, 4'b0000, 16'd10,     1,  4'b0000, 4'b0000, 4'b0001, 4'b0001, 0);
        addVec("release_pulse_end",   0, 4'b0000, 16'd10,     1,  4'b0000, 4'b0000, 4'b0000, 4'b0001, 0);
        addVec("release_hold",        0, 4'b0000, 16'd10,     15, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0);
        addVec("thr0_sampled",        0, 4'b0001, 16'd0,      1,  4'b0000, 4'b0000, 4'b0000, 4'b0001, 0);
        addVec("thr0_synced",         0, 4'b0000, 16'd0,      1,  4'b0000, 4'b0000, 4'b0000, 4'b0001, 0);
        addVec("thr0_rise",           0, 4'b0000, 16'd0,      1,  4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
        addVec("thr0_fall",           0, 4'b0000, 16'd0,      1,  4'b0000, 4'b0000, 4'b0001, 4'b0000, 0);
        addVec("thr0_quiet",          0, 4'b0000, 16'd0,      5,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        addVec("thrmax_check",        0, 4'b1000, 16'hFFFF,   3,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
        addVec("thrmax_no_early",     0, 4'b1000, 16'hFFFF,   300,4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
        addVec("thrmax_release_sync", 0, 4'b0000, 16'hFFFF,   2,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
        addVec("thrmax_abort",        0, 4'b0000, 16'hFFFF,   1,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);

        for (int i = 0; i < nVec; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].sw, vecs[i].cfg, vecs[i].cycles);
            checkOutput(vecNames[i], vecs[i].db, vecs[i].rise, vecs[i].fall,
                        vecs[i].tog, vecs[i].busy);
        end

        // Short bounces (1..8 cycles) on channel 1 must never be accepted.
        doReset();
        obsRise = 0;
        obsFall = 0;
        obsHigh = 0;
        for (int pulse = 0; pulse < 50; pulse++) begin
            for (int lvl = 1; lvl >= 0; lvl--) begin
                w = int'($urandom_range(8, 1));
                sw[1] = lvl[0];
                for (int c = 0; c < w; c++) begin
                    @(negedge clk);
                    obsRise += int'(rise[1]);
                    obsFall += int'(fall[1]);
                    obsHigh += int'(db[1]);
                end
            end
        end
        sw[1] = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            obsRise += int'(rise[1]);
            obsFall += int'(fall[1]);
            obsHigh += int'(db[1]);
        end
        checkValue("bounce8_rise_count", obsRise, 0);
        checkValue("bounce8_fall_count", obsFall, 0);
        checkValue("bounce8_db_high_cycles", obsHigh, 0);

        // Longer bounces (1..15 cycles) against the sliding-window model.
        doReset();
        pIdx  = 0;
        mDb   = 1'b0;
        mRise = 0;
        mFall = 0;
        dRise = 0;
        dFall = 0;
        dbBad = 0;
        for (int pulse = 0; pulse < 50; pulse++) begin
            for (int lvl = 1; lvl >= 0; lvl--) begin
                w = int'($urandom_range(15, 1));
                for (int c = 0; c < w; c++) stepCh1(lvl[0]);
            end
        end
        for (int c = 0; c < 20; c++) stepCh1(1'b0);
        checkValue("bounce15_db_trace_errors", dbBad, 0);
        checkValue("bounce15_rise_count", dRise, mRise);
        checkValue("bounce15_fall_count", dFall, mFall);

        // Channels 2 and 3 pressed together while channel 0 bounces with
        // 3-cycle pulses.
        doReset();
        riseP2  = -1;
        riseP3  = -1;
        busyBad = 0;
        db0Bad  = 0;
        for (int c = 0; c < 30; c++) begin
            sw = {2'b11, 1'b0, ((c / 3) % 2) == 1};
            @(negedge clk);
            if (rise[2] && riseP2 < 0) riseP2 = c + 1;
            if (rise[3] && riseP3 < 0) riseP3 = c + 1;
            if (db[0] || rise[0] || fall[0]) db0Bad++;
            if ((c + 1) < 3 && busy) busyBad++;
            if ((c + 1) >= 3 && (c + 1) <= 11 && !busy) busyBad++;
        end
        checkValue("indep_rise2_edge", riseP2, 12);
        checkValue("indep_rise3_edge", riseP3, 12);
        checkValue("indep_ch0_activity", db0Bad, 0);
        checkValue("indep_busy_window_errors", busyBad, 0);
        applyStimulus(1'b0, 4'b1100, 16'd10, 15);
        checkOutput("indep_settled", 4'b1100, 4'b0000, 4'b0000, 4'b1100, 0);

        // Lowering the threshold from 10 to 3 once the count reaches 5.
        doReset();
        applyStimulus(1'b0, 4'b0001, 16'd10, 7);
        checkOutput("thr_cnt5", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
        applyStimulus(1'b0, 4'b0001, 16'd3, 1);
        checkOutput("thr_lowered_commit", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0);

        // Reset asserted with channel 0 in CHECK_HI at a count of 7.
        doReset();
        applyStimulus(1'b0, 4'b0001, 16'd10, 9);
        checkOutput("midrst_counting", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_async", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        repeat (2) @(negedge clk);
        checkOutput("midrst_held", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        applyStimulus(1'b0, 4'b0001, 16'd10, 11);
        checkOutput("midrst_fresh_wait", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
        applyStimulus(1'b0, 4'b0001, 16'd10, 1);
        checkOutput("midrst_fresh_commit", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
